irq_arbiter: RTL and testbench
==============================

// Module: irq_arbiter
// PURPOSE
//  Interrupt controller between the peripheral interrupt lines (mouse, timer, switches) and the
//  Processor's per-bit RAISE/ACK interrupt port. Latches source requests as pending bits, applies a
//  bus-writable enable mask, and dispatches one interrupt at a time by fixed priority. Relays the
//  Processor ack back to the owning source. Mask/pending/status registers sit on the shared 8-bit data bus.
// PARAMETERS
//  N_SRC      3      number of interrupt sources, legal range 1..8; bit i = source i
//  BASE_ADDR  8'hE0  bus address of ENABLE; PENDING = BASE+1; STATUS = BASE+2
// PORTS
//  CLK            in     1      system clock, 100 MHz
//  RESET          in     1      synchronous, active-high reset
//  BUS_DATA       inout  8      shared data bus; driven only during a register read
//  BUS_ADDR       in     8      shared address bus
//  BUS_WE         in     1      bus write strobe
//  SRC_RAISE      in     N_SRC  peripheral requests; a level held until SRC_ACK
//  SRC_ACK        out    N_SRC  one-cycle ack pulse to the serviced source
//  CPU_IRQ_RAISE  out    N_SRC  one-hot request to the Processor, held until CPU_IRQ_ACK
//  CPU_IRQ_ACK    in     N_SRC  Processor ack; only the bit matching CPU_IRQ_RAISE is honoured
// BEHAVIOUR
//  Reset: ENABLE=all 1s (N_SRC bits); PENDING=0; state IDLE; SRC_ACK=0; CPU_IRQ_RAISE=0; bus released (Z).
//  Capture: a rising edge of SRC_RAISE[i] (registered previous value) sets PENDING[i] on the next edge.
//   A held level does not re-set PENDING. Previous-value regs reset to 0, so a line high at reset release
//   counts as a rising edge.
//  Registers:
//   ENABLE  RW  bits[N_SRC-1:0]. Upper bits read 0.
//   PENDING R / W1C. A write of 1 clears that bit. A same-cycle set wins over any clear.
//   STATUS  R   [7]=busy (state != IDLE), [2:0]=in-service id, [6:3]=0.
//  Bus write: takes effect on the clock edge where BUS_WE=1 and BUS_ADDR matches.
//  Bus read: for BUS_ADDR in BASE..BASE+2 with BUS_WE=0, read data and output enable are registered.
//   BUS_DATA is driven the cycle after the address, and is Z otherwise.
//  FSM, states in package enum:
//   IDLE  : pick = lowest index i with PENDING[i]&ENABLE[i]. If any, latch id -> RAISE.
//   RAISE : CPU_IRQ_RAISE = onehot(id), registered.
//           CPU_IRQ_ACK[id]=1 -> pulse SRC_ACK[id] for 1 cycle, clear PENDING[id] -> GAP.
//   GAP   : 1 cycle with RAISE deasserted (lets the source drop its line) -> IDLE.
//  Dispatch latency: pending+enabled visible in IDLE -> CPU_IRQ_RAISE high 1 cycle later.
//   CPU ack -> SRC_ACK pulse the next cycle.
//  Boundaries:
//   - Masking the in-service source mid-RAISE does not abort it; service completes.
//   - Masked pending bits persist. Unmasking dispatches them from IDLE.
//   - A new edge on the in-service source during RAISE/GAP re-sets PENDING[id] and dispatches again.
//   - A W1C of the in-service bit during RAISE does not abort; the bit is cleared anyway at ack.
//   - Ack on a non-matching bit is ignored.
//   - Simultaneous edges: all latched; the lowest index is served first, the others in order afterwards.
//   - RESET mid-operation: immediate return to reset values, no ack pulse issued.
// STRUCTURE
//  irq_arbiter_pkg: state enum {IDLE,RAISE,GAP}, register offsets (OFS_ENABLE=0, OFS_PENDING=1,
//   OFS_STATUS=2), STATUS bit positions.
//  Sub-module irq_prio_enc: combinational fixed-priority picker.
//   Inputs: request vector [N_SRC-1:0]. Outputs: valid, id[2:0].
// TESTING
//  1 Reset, read STATUS and PENDING -> 8'h00 both. Read ENABLE -> 8'h07 (N_SRC=3). No RAISE, no bus drive.
//  2 SRC_RAISE=3'b010 held, CPU acks 3 cycles after RAISE -> CPU_IRQ_RAISE=3'b010.
//    Then SRC_ACK[1] 1-cycle pulse, PENDING=0, no re-dispatch while the line stays high.
//  3 SRC_RAISE 3'b000->3'b111 in one cycle -> served in order id 0,1,2.
//    One-cycle GAP between each; STATUS[2:0] tracks the id.
//  4 Write ENABLE=8'h06, raise src0 -> no dispatch, PENDING=8'h01.
//    Write ENABLE=8'h07 -> src0 dispatched 2 cycles after the write.
//  5 Raise src2, ack on bit 0 only -> ignored, RAISE held. Then W1C PENDING=8'h04 -> still RAISE.
//    Correct ack -> completes.
//  6 RESET asserted during RAISE -> next cycle all outputs at reset values, BUS_DATA Z, no SRC_ACK pulse.

Source files
------------

// File: rtl/irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter: FSM states,
// register offsets from BASE_ADDR and the STATUS word layout.
package irq_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAISE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [1:0] OFS_ENABLE  = 2'd0;
  localparam logic [1:0] OFS_PENDING = 2'd1;
  localparam logic [1:0] OFS_STATUS  = 2'd2;

  localparam int STATUS_BUSY_BIT = 7;
  localparam int STATUS_ID_MSB   = 2;
  localparam int STATUS_ID_LSB   = 0;

  // The id field only means something while a request is in flight, so it reads 0 when idle.
  function automatic logic [7:0] status_word(input logic busy, input logic [2:0] id);
    logic [7:0] w;
    w = 8'h00;
    w[STATUS_BUSY_BIT] = busy;
    if (busy) w[STATUS_ID_MSB:STATUS_ID_LSB] = id;
    return w;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority picker: the lowest set request bit wins.
module irq_prio_enc #(
  parameter int N_SRC = 3
) (
  input  logic [N_SRC-1:0] i_req,
  output logic             o_valid,
  output logic [2:0]       o_id
);

  always_comb begin
    o_valid = 1'b0;
    o_id    = 3'd0;
    // Scanning downwards lets the lowest index overwrite any higher one.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_id    = 3'(i);
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt arbiter: latches source edges as pending bits, masks them with ENABLE,
// dispatches one at a time to the CPU and relays the CPU ack back to the source.
import irq_arbiter_pkg::*;

module irq_arbiter #(
  parameter int         N_SRC     = 3,
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic             CLK,
  input  logic             RESET,
  inout  wire  [7:0]       BUS_DATA,
  input  logic [7:0]       BUS_ADDR,
  input  logic             BUS_WE,
  input  logic [N_SRC-1:0] SRC_RAISE,
  output logic [N_SRC-1:0] SRC_ACK,
  output logic [N_SRC-1:0] CPU_IRQ_RAISE,
  input  logic [N_SRC-1:0] CPU_IRQ_ACK
);

  localparam logic [7:0] ADDR_ENABLE  = BASE_ADDR + {6'd0, OFS_ENABLE};
  localparam logic [7:0] ADDR_PENDING = BASE_ADDR + {6'd0, OFS_PENDING};
  localparam logic [7:0] ADDR_STATUS  = BASE_ADDR + {6'd0, OFS_STATUS};

  state_t           r_state, w_state_next;
  logic [2:0]       r_id, w_id_next;
  logic [N_SRC-1:0] r_enable, r_pending, r_src_prev, r_src_ack, r_cpu_raise;
  logic             r_rd_oe;
  logic [7:0]       r_rd_data;

  logic [N_SRC-1:0] w_rise, w_w1c, w_ack_clr, w_pending_next;
  logic [N_SRC-1:0] w_cpu_raise_next, w_src_ack_next;
  logic [N_SRC-1:0] w_id_onehot, w_pick_onehot;
  logic             w_pick_valid, w_acked, w_rd_hit;
  logic [2:0]       w_pick_id;
  logic [7:0]       w_rd_data;

  irq_prio_enc #(.N_SRC(N_SRC)) u_prio_enc (
    .i_req   (r_pending & r_enable),
    .o_valid (w_pick_valid),
    .o_id    (w_pick_id)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_onehot
      assign w_id_onehot[gi]   = (r_id == 3'(gi));
      assign w_pick_onehot[gi] = (w_pick_id == 3'(gi));
    end
    if (N_SRC < 8) begin : g_wdata_pad
      logic w_unused_wdata;
      assign w_unused_wdata = ^BUS_DATA[7:N_SRC];
    end
  endgenerate

  assign w_rise  = SRC_RAISE & ~r_src_prev;
  assign w_w1c   = (BUS_WE && BUS_ADDR == ADDR_PENDING) ? BUS_DATA[N_SRC-1:0] : '0;
  assign w_acked = (r_state == RAISE) && |(CPU_IRQ_ACK & w_id_onehot);
  // A fresh edge in the same cycle beats both a W1C and the ack clear.
  assign w_pending_next = (r_pending & ~(w_w1c | w_ack_clr)) | w_rise;

  always_comb begin
    w_state_next     = r_state;
    w_id_next        = r_id;
    w_cpu_raise_next = '0;
    w_src_ack_next   = '0;
    w_ack_clr        = '0;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_state_next     = RAISE;
          w_id_next        = w_pick_id;
          w_cpu_raise_next = w_pick_onehot;
        end
      end
      RAISE: begin
        if (w_acked) begin
          w_state_next   = GAP;
          w_src_ack_next = w_id_onehot;
          w_ack_clr      = w_id_onehot;
        end else begin
          w_cpu_raise_next = w_id_onehot;
        end
      end
      GAP:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_rd_hit  = !BUS_WE && (BUS_ADDR == ADDR_ENABLE || BUS_ADDR == ADDR_PENDING ||
                            BUS_ADDR == ADDR_STATUS);
    w_rd_data = 8'h00;
    if (BUS_ADDR == ADDR_ENABLE) begin
      w_rd_data[N_SRC-1:0] = r_enable;
    end else if (BUS_ADDR == ADDR_PENDING) begin
      w_rd_data[N_SRC-1:0] = r_pending;
    end else if (BUS_ADDR == ADDR_STATUS) begin
      w_rd_data = status_word(r_state != IDLE, r_id);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_id        <= 3'd0;
      r_enable    <= '1;
      r_pending   <= '0;
      r_src_prev  <= '0;
      r_src_ack   <= '0;
      r_cpu_raise <= '0;
      r_rd_oe     <= 1'b0;
      r_rd_data   <= 8'h00;
    end else begin
      r_state     <= w_state_next;
      r_id        <= w_id_next;
      r_pending   <= w_pending_next;
      r_src_prev  <= SRC_RAISE;
      r_src_ack   <= w_src_ack_next;
      r_cpu_raise <= w_cpu_raise_next;
      r_rd_oe     <= w_rd_hit;
      r_rd_data   <= w_rd_data;
      if (BUS_WE && BUS_ADDR == ADDR_ENABLE) r_enable <= BUS_DATA[N_SRC-1:0];
    end
  end

  assign SRC_ACK       = r_src_ack;
  assign CPU_IRQ_RAISE = r_cpu_raise;
  assign BUS_DATA      = r_rd_oe ? r_rd_data : 8'hzz;

endmodule

// File: tb/tb_irq_arbiter.sv
// Bench for irq_arbiter: directed scenarios with literal expectations, then random traffic,
// all outputs compared every cycle against a behavioural model of the arbiter.
module tb_irq_arbiter;

  localparam int         N    = 3;
  localparam logic [7:0] BASE = 8'hE0;

  logic         clk = 1'b0;
  logic         rst;
  wire  [7:0]   bus_data;
  logic [7:0]   addr, wdata;
  logic         we;
  logic [N-1:0] src, cpu_ack, src_ack, cpu_raise;
  logic         tb_oe;

  int errors = 0;
  int checks = 0;
  bit live   = 1'b0;

  // Behavioural model: what the arbiter is doing, not how it encodes it.
  bit [N-1:0] m_en, m_pend, m_prev, m_raise, m_srcack;
  bit         m_serving, m_gap, m_rd_oe;
  int         m_id;
  bit [7:0]   m_rd_data;

  always #5 clk = ~clk;

  assign tb_oe    = !m_rd_oe;
  assign bus_data = tb_oe ? wdata : 8'hzz;

  irq_arbiter #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
    .CLK           (clk),
    .RESET         (rst),
    .BUS_DATA      (bus_data),
    .BUS_ADDR      (addr),
    .BUS_WE        (we),
    .SRC_RAISE     (src),
    .SRC_ACK       (src_ack),
    .CPU_IRQ_RAISE (cpu_raise),
    .CPU_IRQ_ACK   (cpu_ack)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] rise, clr, avail;
    bit         found;
    if (rst) begin
      m_en = '1; m_pend = '0; m_prev = '0; m_raise = '0; m_srcack = '0;
      m_serving = 1'b0; m_gap = 1'b0; m_id = 0; m_rd_oe = 1'b0; m_rd_data = 8'h00;
      return;
    end
    m_rd_oe   = !we && addr >= BASE && addr <= BASE + 8'd2;
    m_rd_data = 8'h00;
    if (addr == BASE)              m_rd_data = 8'(m_en);
    else if (addr == BASE + 8'd1)  m_rd_data = 8'(m_pend);
    else if (addr == BASE + 8'd2)  m_rd_data = (m_serving || m_gap) ? (8'h80 | 8'(m_id)) : 8'h00;
    rise   = src & ~m_prev;
    m_prev = src;
    clr    = (we && addr == BASE + 8'd1) ? wdata[N-1:0] : '0;
    avail  = m_pend & m_en;
    m_srcack = '0;
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_serving) begin
      if (cpu_ack[m_id]) begin
        clr[m_id] = 1'b1; m_srcack[m_id] = 1'b1;
        m_raise = '0; m_serving = 1'b0; m_gap = 1'b1;
      end
    end else begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!found && avail[i]) begin found = 1'b1; m_id = i; end
      end
      if (found) begin m_serving = 1'b1; m_raise = '0; m_raise[m_id] = 1'b1; end
    end
    if (we && addr == BASE) m_en = wdata[N-1:0];
    m_pend = (m_pend & ~clr) | rise;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (live) begin
      chk("cpu_irq_raise", 8'(cpu_raise), 8'(m_raise));
      chk("src_ack", 8'(src_ack), 8'(m_srcack));
      if (m_rd_oe) chk("bus_read", bus_data, m_rd_data);
      else         chk("bus_release", bus_data, wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    addr = 8'h00; we = 1'b0; wdata = 8'hA5;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    addr = a; we = 1'b1; wdata = d;
    tick();
    idle_bus();
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [7:0] exp, input string name);
    addr = a; we = 1'b0;
    tick();
    chk(name, bus_data, exp);
    idle_bus();
    tick();
  endtask

  task automatic wait_raise(input string name, output int n);
    n = 0;
    while (cpu_raise == '0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (cpu_raise == '0) begin
      errors++;
      $display("FAIL %s: no CPU_IRQ_RAISE within %0d cycles", name, n);
    end
  endtask

  initial begin
    int n;
    int r;
    rst = 1'b1; src = '0; cpu_ack = '0;
    idle_bus();
    repeat (3) tick();
    live = 1'b1;
    rst  = 1'b0;

    // Reset values
    chk("rst_raise", 8'(cpu_raise), 8'h00);
    bus_read(BASE + 8'd2, 8'h00, "rst_status");
    bus_read(BASE + 8'd1, 8'h00, "rst_pending");
    bus_read(BASE,        8'h07, "rst_enable");

    // Single held source
    src = 3'b010;
    wait_raise("t2_wait", n);
    chk("t2_latency", 8'(n), 8'd2);
    chk("t2_raise", 8'(cpu_raise), 8'h02);
    repeat (2) tick();
    cpu_ack = 3'b010;
    tick();
    cpu_ack = '0;
    chk("t2_src_ack", 8'(src_ack), 8'h02);
    tick();
    chk("t2_src_ack_end", 8'(src_ack), 8'h00);
    repeat (4) tick();
    chk("t2_no_redispatch", 8'(cpu_raise), 8'h00);
    bus_read(BASE + 8'd1, 8'h00, "t2_pending");

    // Simultaneous edges served in index order
    src = '0;
    tick();
    src = 3'b111;
    for (int k = 0; k < N; k++) begin
      wait_raise("t3_wait", n);
      chk("t3_raise", 8'(cpu_raise), 8'(1 << k));
      bus_read(BASE + 8'd2, 8'h80 | 8'(k), "t3_status");
      cpu_ack = N'(1 << k);
      tick();
      cpu_ack = '0;
      chk("t3_src_ack", 8'(src_ack), 8'(1 << k));
      tick();
      chk("t3_gap", 8'(cpu_raise), 8'h00);
    end

    // Masked source stays pending until unmasked
    src = '0;
    bus_write(BASE, 8'h06);
    src = 3'b001;
    repeat (4) tick();
    chk("t4_masked", 8'(cpu_raise), 8'h00);
    bus_read(BASE + 8'd1, 8'h01, "t4_pending_masked");
    bus_write(BASE, 8'h07);
    chk("t4_not_yet", 8'(cpu_raise), 8'h00);
    tick();
    chk("t4_dispatch", 8'(cpu_raise), 8'h01);
    cpu_ack = 3'b001;
    tick();
    cpu_ack = '0;
    repeat (2) tick();

    // Wrong ack ignored, W1C of in-service bit does not abort
    src = '0;
    tick();
    src = 3'b100;
    wait_raise("t5_wait", n);
    chk("t5_raise", 8'(cpu_raise), 8'h04);
    cpu_ack = 3'b001;
    tick();
    cpu_ack = '0;
    chk("t5_wrong_ack", 8'(src_ack), 8'h00);
    chk("t5_held", 8'(cpu_raise), 8'h04);
    bus_write(BASE + 8'd1, 8'h04);
    chk("t5_w1c_held", 8'(cpu_raise), 8'h04);
    cpu_ack = 3'b100;
    tick();
    cpu_ack = '0;
    chk("t5_src_ack", 8'(src_ack), 8'h04);
    tick();
    bus_read(BASE + 8'd1, 8'h00, "t5_pending");

    // Reset in the middle of a RAISE, with an ack arriving at the same edge
    src = '0;
    tick();
    src = 3'b010;
    wait_raise("t6_wait", n);
    chk("t6_raise_before", 8'(cpu_raise), 8'h02);
    rst = 1'b1; cpu_ack = 3'b010; src = '0;
    tick();
    rst = 1'b0; cpu_ack = '0;
    chk("t6_raise", 8'(cpu_raise), 8'h00);
    chk("t6_src_ack", 8'(src_ack), 8'h00);
    chk("t6_bus", bus_data, wdata);
    bus_read(BASE + 8'd2, 8'h00, "t6_status");
    bus_read(BASE,        8'h07, "t6_enable");

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (src_ack[i] && $urandom_range(0, 1) == 0) src[i] = 1'b0;
        else if ($urandom_range(0, 15) == 0)        src[i] = ~src[i];
      end
      cpu_ack = '0;
      if (cpu_raise != '0 && $urandom_range(0, 2) == 0) cpu_ack = cpu_raise;
      else if ($urandom_range(0, 9) == 0)               cpu_ack = N'($urandom);
      idle_bus();
      r = int'($urandom_range(0, 11));
      if (r < 2) begin
        addr = BASE + 8'($urandom_range(0, 3));
      end else if (r == 2 && !m_rd_oe) begin
        addr  = BASE + 8'($urandom_range(0, 1));
        we    = 1'b1;
        wdata = 8'($urandom);
      end else begin
        addr = 8'($urandom_range(0, 8'hDF));
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0; src = '0; cpu_ack = '0;
    idle_bus();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
